// File: rtl/lfm_chirp_seq.sv
// Burst sequencer for the LFM DDS core. It turns a start pulse and a configuration
// latched at arm time into a train of linear-FM chirps separated by silent gaps.
module lfm_chirp_seq #(
  parameter int N_PHASE = 32,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [N_PHASE-1:0] cfg_ftw0,
  input  logic [N_PHASE-1:0] cfg_dftw,
  input  logic [1:0]         cfg_mode,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [LEN_W-1:0]   cfg_gap,
  input  logic [CNT_W-1:0]   cfg_num,
  output logic [N_PHASE-1:0] ftw_out,
  output logic               phase_clr,
  output logic               dds_en,
  output logic               chirp_start,
  output logic [CNT_W-1:0]   chirp_idx,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CHIRP,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_ALT  = 2'd2;

  state_t             state_q, state_d;

  // configuration captured in ARM
  logic [N_PHASE-1:0] ftw0_q, ftw0_d;
  logic [N_PHASE-1:0] dftw_q, dftw_d;
  logic [1:0]         mode_q, mode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   num_q, num_d;

  // sample counter is shared between CHIRP and GAP
  logic [LEN_W-1:0]   samp_q, samp_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               down_q, down_d;

  logic [N_PHASE-1:0] ftw_q, ftw_d;
  logic               phase_clr_q, phase_clr_d;
  logic               dds_en_q, dds_en_d;
  logic               chirp_start_q, chirp_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0]   idx_inc;
  logic               last_samp;
  logic               last_gap;
  logic               burst_end;

  function automatic logic dir_down(input logic [1:0] mode, input logic odd);
    return (mode == MODE_DOWN) || ((mode == MODE_ALT) && odd);
  endfunction

  assign idx_inc   = idx_q + CNT_W'(1);
  assign last_samp = (samp_q == (len_q - LEN_W'(1)));
  assign last_gap  = (samp_q == (gap_q - LEN_W'(1)));
  assign burst_end = (num_q != '0) && (idx_inc == num_q);

  always_comb begin
    state_d       = state_q;
    ftw0_d        = ftw0_q;
    dftw_d        = dftw_q;
    mode_d        = mode_q;
    len_d         = len_q;
    gap_d         = gap_q;
    num_d         = num_q;
    samp_d        = samp_q;
    idx_d         = idx_q;
    down_d        = down_q;
    ftw_d         = '0;
    phase_clr_d   = 1'b0;
    dds_en_d      = 1'b0;
    chirp_start_d = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          if (cfg_len != '0) begin
            state_d = S_ARM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_ARM: begin
        idx_d = '0;
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          ftw0_d        = cfg_ftw0;
          dftw_d        = cfg_dftw;
          mode_d        = cfg_mode;
          len_d         = cfg_len;
          gap_d         = cfg_gap;
          num_d         = cfg_num;
          samp_d        = '0;
          down_d        = dir_down(cfg_mode, 1'b0);
          state_d       = S_CHIRP;
          ftw_d         = cfg_ftw0;
          phase_clr_d   = 1'b1;
          chirp_start_d = 1'b1;
          dds_en_d      = 1'b1;
        end
      end

      S_CHIRP: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (last_samp) begin
          idx_d  = idx_inc;
          samp_d = '0;
          if (burst_end) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
          end else begin
            // zero gap: next chirp starts on the very next sample
            state_d       = S_CHIRP;
            down_d        = dir_down(mode_q, idx_inc[0]);
            ftw_d         = ftw0_q;
            phase_clr_d   = 1'b1;
            chirp_start_d = 1'b1;
            dds_en_d      = 1'b1;
          end
        end else begin
          samp_d   = samp_q + LEN_W'(1);
          ftw_d    = down_q ? (ftw_q - dftw_q) : (ftw_q + dftw_q);
          dds_en_d = 1'b1;
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (last_gap) begin
          state_d       = S_CHIRP;
          samp_d        = '0;
          down_d        = dir_down(mode_q, idx_q[0]);
          ftw_d         = ftw0_q;
          phase_clr_d   = 1'b1;
          chirp_start_d = 1'b1;
          dds_en_d      = 1'b1;
        end else begin
          samp_d = samp_q + LEN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ftw0_q        <= '0;
      dftw_q        <= '0;
      mode_q        <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      num_q         <= '0;
      samp_q        <= '0;
      idx_q         <= '0;
      down_q        <= 1'b0;
      ftw_q         <= '0;
      phase_clr_q   <= 1'b0;
      dds_en_q      <= 1'b0;
      chirp_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ftw0_q        <= ftw0_d;
      dftw_q        <= dftw_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      num_q         <= num_d;
      samp_q        <= samp_d;
      idx_q         <= idx_d;
      down_q        <= down_d;
      ftw_q         <= ftw_d;
      phase_clr_q   <= phase_clr_d;
      dds_en_q      <= dds_en_d;
      chirp_start_q <= chirp_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign ftw_out     = ftw_q;
  assign phase_clr   = phase_clr_q;
  assign dds_en      = dds_en_q;
  assign chirp_start = chirp_start_q;
  assign chirp_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_lfm_chirp_seq.sv
// Bench for lfm_chirp_seq: a per-cycle expectation table is filled from the burst
// rules whenever a start is issued, and every cycle's outputs are compared to it.
module tb_lfm_chirp_seq;
  localparam int MEM = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_ftw0 = '0;
  logic [31:0] cfg_dftw = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_gap = '0;
  logic [7:0]  cfg_num = '0;
  logic [31:0] ftw_out;
  logic        phase_clr, dds_en, chirp_start, busy, done, cfg_err;
  logic [7:0]  chirp_idx;

  typedef struct packed {
    logic [31:0] ftw;
    logic        phase_clr;
    logic        dds_en;
    logic        chirp_start;
    logic [7:0]  idx;
    logic        busy;
    logic        done;
    logic        cfg_err;
  } exp_t;

  exp_t exp_mem [MEM];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  lfm_chirp_seq #(.N_PHASE(32), .LEN_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_ftw0(cfg_ftw0), .cfg_dftw(cfg_dftw), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num(cfg_num),
    .ftw_out(ftw_out), .phase_clr(phase_clr), .dds_en(dds_en),
    .chirp_start(chirp_start), .chirp_idx(chirp_idx), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // per-cycle comparison against the expectation table
  always @(negedge clk) begin
    if (chk_en && cyc < MEM) begin
      check("ftw_out",     ftw_out,     exp_mem[cyc].ftw);
      check("phase_clr",   phase_clr,   exp_mem[cyc].phase_clr);
      check("dds_en",      dds_en,      exp_mem[cyc].dds_en);
      check("chirp_start", chirp_start, exp_mem[cyc].chirp_start);
      check("chirp_idx",   chirp_idx,   exp_mem[cyc].idx);
      check("busy",        busy,        exp_mem[cyc].busy);
      check("done",        done,        exp_mem[cyc].done);
      check("cfg_err",     cfg_err,     exp_mem[cyc].cfg_err);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp(input int a, input int b);
    for (int i = a; i <= b; i++) exp_mem[i] = '0;
  endtask

  // Expected activity of a burst started in cycle c: ARM at c+1, samples from c+2.
  task automatic plan(input int c, input logic [31:0] f0, input logic [31:0] d,
                      input logic [1:0] m, input int len, input int gap, input int num,
                      input int lim, output int endc, output int wend);
    exp_t e;
    int   t;
    int   k;
    bit   fin;
    logic dn;
    t = c + 1;
    e = '0;
    e.busy = 1'b1;
    exp_mem[t] = e;
    t++;
    k = 0;
    fin = 1'b0;
    endc = t;
    wend = t;
    while (!fin) begin
      dn = (m == 2'd1) || (m == 2'd2 && (k % 2) == 1);
      for (int s = 0; s < len; s++) begin
        e = '0;
        e.busy = 1'b1;
        e.dds_en = 1'b1;
        e.idx = k[7:0];
        e.ftw = dn ? (f0 - d * 32'(s)) : (f0 + d * 32'(s));
        e.phase_clr = (s == 0);
        e.chirp_start = (s == 0);
        exp_mem[t] = e;
        t++;
      end
      k++;
      if (num != 0 && k == num) begin
        e = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.idx = k[7:0];
        exp_mem[t] = e;
        endc = t;
        wend = t;
        fin = 1'b1;
      end else begin
        for (int g = 0; g < gap; g++) begin
          e = '0;
          e.busy = 1'b1;
          e.idx = k[7:0];
          exp_mem[t] = e;
          t++;
        end
        if (num == 0 && t > c + lim) begin
          endc = c + lim;
          wend = t - 1;
          fin = 1'b1;
        end
      end
    end
  endtask

  // sa/xs/ra: cycle offsets from start for stop, ignored start, reset (-1 = none)
  task automatic run_burst(input logic [31:0] f0, input logic [31:0] d, input logic [1:0] m,
                           input int len, input int gap, input int num,
                           input int sa, input int xs, input int ra, input int lim,
                           output int s);
    int endc;
    int wend;
    int rel;
    s = cyc;
    cfg_ftw0 = f0;
    cfg_dftw = d;
    cfg_mode = m;
    cfg_len = 16'(len);
    cfg_gap = 16'(gap);
    cfg_num = 8'(num);
    start = 1'b1;
    stop = ($urandom_range(0, 3) == 0);
    plan(s, f0, d, m, len, gap, num, lim, endc, wend);
    tick();
    while (cyc <= endc) begin
      rel = cyc - s;
      start = 1'b0;
      stop = 1'b0;
      if (rel >= 2) begin
        cfg_ftw0 = $urandom;
        cfg_dftw = $urandom;
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_len = 16'($urandom_range(0, 3));
        cfg_gap = 16'($urandom_range(0, 3));
        cfg_num = 8'($urandom_range(0, 3));
        if (rel == xs) start = 1'b1;
      end
      if (rel == ra && rst_n) begin
        rst_n = 1'b0;
        clear_exp(cyc, wend);
        #1;
        check("async_rst_ftw", ftw_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_en", dds_en, 0);
        check("async_rst_idx", chirp_idx, 0);
        endc = cyc + 1;
      end else if (rel == sa && rst_n) begin
        stop = 1'b1;
        if (num == 0 || cyc < endc) begin
          clear_exp(cyc + 1, wend);
          endc = cyc;
        end
      end
      tick();
    end
    start = 1'b0;
    stop = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic pin_s1(input int s);
    logic [31:0] ref_ftw [4];
    ref_ftw[0] = 32'h0000A7C6;
    ref_ftw[1] = 32'h0000A7C7;
    ref_ftw[2] = 32'h0000A7C8;
    ref_ftw[3] = 32'h0000A7C9;
    for (int i = 0; i < 4; i++) begin
      check("pin_s1_ftw", exp_mem[s + 2 + i].ftw, ref_ftw[i]);
      check("pin_s1_cs", exp_mem[s + 2 + i].chirp_start, (i == 0));
      check("pin_s1_pc", exp_mem[s + 2 + i].phase_clr, (i == 0));
    end
    check("pin_s1_done", exp_mem[s + 6].done, 1);
    check("pin_s1_idle", exp_mem[s + 7].busy, 0);
  endtask

  initial begin
    int          s;
    int          len, gap, num, lim, total, sa, xs, ra, ncs;
    logic [1:0]  mode;
    logic [31:0] f0, d;
    logic [12:0] pat;
    logic [31:0] ref3 [6];

    for (int i = 0; i < MEM; i++) exp_mem[i] = '0;
    chk_en = 1'b1;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_ftw", ftw_out, 0);
    check("reset_en", dds_en, 0);
    rst_n = 1'b1;
    tick();

    // single up-chirp
    run_burst(32'h0000A7C6, 32'd1, 2'd0, 4, 0, 1, -1, -1, -1, 200, s);
    pin_s1(s);

    // burst with gaps
    run_burst($urandom, $urandom, 2'd0, 3, 2, 3, -1, -1, -1, 200, s);
    pat = 13'b1110011100111;
    ncs = 0;
    for (int i = 0; i < 13; i++) begin
      check("pin_s2_en", exp_mem[s + 2 + i].dds_en, pat[12 - i]);
      ncs += int'(exp_mem[s + 2 + i].chirp_start);
    end
    check("pin_s2_ncs", ncs, 3);
    check("pin_s2_idx0", exp_mem[s + 2].idx, 0);
    check("pin_s2_idx1", exp_mem[s + 7].idx, 1);
    check("pin_s2_idx2", exp_mem[s + 12].idx, 2);
    check("pin_s2_cs2", exp_mem[s + 12].chirp_start, 1);
    check("pin_s2_done", exp_mem[s + 15].done, 1);

    // alternate direction with wrap
    run_burst(32'h00000001, 32'd2, 2'd2, 3, 0, 2, -1, -1, -1, 200, s);
    ref3[0] = 32'h1; ref3[1] = 32'h3; ref3[2] = 32'h5;
    ref3[3] = 32'h1; ref3[4] = 32'hFFFFFFFF; ref3[5] = 32'hFFFFFFFD;
    for (int i = 0; i < 6; i++) check("pin_s3_ftw", exp_mem[s + 2 + i].ftw, ref3[i]);
    check("pin_s3_cs", exp_mem[s + 5].chirp_start, 1);
    check("pin_s3_done", exp_mem[s + 8].done, 1);

    // continuous, stopped mid-chirp after chirp_idx passes 3
    run_burst($urandom, $urandom, 2'd0, 5, 1, 0, 28, -1, -1, 100, s);
    check("pin_s4_idx", exp_mem[s + 28].idx, 4);
    check("pin_s4_en", exp_mem[s + 28].dds_en, 1);
    check("pin_s4_stop", exp_mem[s + 29].busy, 0);

    // illegal length, then a start while busy
    cfg_len = '0;
    start = 1'b1;
    exp_mem[cyc + 1].cfg_err = 1'b1;
    check("pin_s5_err", exp_mem[cyc + 1].cfg_err, 1);
    tick();
    start = 1'b0;
    tick();
    run_burst(32'h0000A7C6, 32'd1, 2'd0, 4, 0, 1, -1, 3, -1, 200, s);
    pin_s1(s);

    // reset during a gap, then a fresh single chirp
    run_burst($urandom, $urandom, 2'd0, 3, 2, 3, -1, -1, 5, 200, s);
    check("pin_s6_rst", exp_mem[s + 5].busy, 0);
    run_burst(32'h0000A7C6, 32'd1, 2'd0, 4, 0, 1, -1, -1, -1, 200, s);
    pin_s1(s);

    // one-sample chirps back to back, chirp_idx wraps past 255
    run_burst($urandom, $urandom, 2'd2, 1, 0, 0, 300, -1, -1, 400, s);
    check("pin_wrap_idx", exp_mem[s + 2 + 257].idx, 1);

    for (int n = 0; n < 150; n++) begin
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      num = $urandom_range(0, 4);
      mode = 2'($urandom_range(0, 3));
      f0 = $urandom;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      lim = 40;
      total = (num == 0) ? lim : num * len + (num - 1) * gap + 2;
      sa = -1;
      xs = -1;
      ra = -1;
      if (num == 0) sa = $urandom_range(1, lim - 1);
      else if ($urandom_range(0, 3) == 0) sa = $urandom_range(1, total);
      if ($urandom_range(0, 9) == 0) ra = $urandom_range(1, total - 1);
      if ($urandom_range(0, 2) == 0) xs = $urandom_range(2, total);
      run_burst(f0, d, mode, len, gap, num, sa, xs, ra, lim, s);
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_len = '0;
          start = 1'b1;
          exp_mem[cyc + 1].cfg_err = 1'b1;
        end else begin
          stop = $urandom_range(0, 1) == 1;
        end
        tick();
        start = 1'b0;
        stop = 1'b0;
      end
    end

    repeat (4) tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
